// File: rtl/bp_pkg.sv
// bp_pkg: shared constants and types for the btb_pht branch predictor.
//
// Holds the 2-bit prediction counter encoding, the counter reset value,
// the default geometry and the per-entry record layout for that geometry.
package bp_pkg;

    // Counter encoding: bit 1 is the taken/not-taken prediction.
    localparam logic [1:0] CTR_SNT   = 2'd0;
    localparam logic [1:0] CTR_WNT   = 2'd1;
    localparam logic [1:0] CTR_WT    = 2'd2;
    localparam logic [1:0] CTR_ST    = 2'd3;
    localparam logic [1:0] CTR_RESET = CTR_WNT;

    // Default geometry of btb_pht.
    localparam int BP_IDX_W = 4;
    localparam int BP_PC_W  = 32;
    localparam int BP_TAG_W = BP_PC_W - BP_IDX_W - 2;

    // One table entry in the default geometry.
    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_PC_W-1:0]  target;
        logic [1:0]          ctr;
    } bp_entry_t;

endpackage

// File: rtl/bp_sat_ctr.sv
// bp_sat_ctr: combinational 2-bit saturating counter next-state.
//
// Ports:
//   ctr      in  2  current counter value
//   taken    in  1  resolved branch outcome
//   ctr_nxt  out 2  counter moved one step toward the outcome, saturating at 0 and 3
module bp_sat_ctr
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_nxt
);

    always_comb begin
        ctr_nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                ctr_nxt = ctr + 2'd1;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                ctr_nxt = ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/btb_pht.sv
// btb_pht: direct-mapped branch target buffer with a 2-bit pattern history table.
//
// The fetch PC is looked up combinationally each cycle; a registered copy of the
// lookup is kept for the decode stage. The branch unit allocates entries (wrt)
// and trains the prediction counters (wrp).
//
// Optional feature: define BTB_BYPASS_EN to forward a same-cycle write to the
// index being looked up, so the lookup reflects the post-write entry.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   pc_if            fetch PC
//   stall, flush     hold / clear the decode-stage copy (flush wins)
//   upd_pc           PC of the resolved branch
//   upd_target       resolved branch target
//   taken            resolved outcome
//   wrt              allocate/overwrite the entry at upd_pc
//   wrp              train the counter at upd_pc (only on a tag hit)
//   hp, pred, target fetch-stage {hit, pred[1]}, counter, target (all 0 on miss)
//   hpd, pred_d, target_d  decode-stage copies
module btb_pht
    import bp_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W,
    parameter int PC_W  = BP_PC_W,
    parameter int TAG_W = PC_W - IDX_W - 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] pc_if,
    input  logic            stall,
    input  logic            flush,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    input  logic            taken,
    input  logic            wrt,
    input  logic            wrp,
    output logic [1:0]      hp,
    output logic [1:0]      pred,
    output logic [PC_W-1:0] target,
    output logic [1:0]      hpd,
    output logic [1:0]      pred_d,
    output logic [PC_W-1:0] target_d
);

    localparam int ENTRIES = 1 << IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [1:0]       ctr_nxt;
    logic [1:0]       alloc_ctr;

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [PC_W-1:0]  rd_target;
    logic [1:0]       rd_ctr;
    logic             hit;

    // Byte-offset bits of word-aligned PCs carry no information here.
    logic unused_bits;
    assign unused_bits = ^{pc_if[1:0], upd_pc[1:0]};

    assign idx     = pc_if[IDX_W+1:2];
    assign tag     = pc_if[PC_W-1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[PC_W-1:IDX_W+2];

    // Training only applies to an entry that really belongs to upd_pc.
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign alloc_ctr = taken ? CTR_WT : CTR_WNT;

    bp_sat_ctr u_sat_ctr (
        .ctr     (ctr_q[upd_idx]),
        .taken   (taken),
        .ctr_nxt (ctr_nxt)
    );

    // Table storage: allocation overwrites unconditionally and takes priority
    // over training, so wrt+wrp gives a fresh counter with no extra step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else if (wrt) begin
            valid_q[upd_idx]  <= 1'b1;
            tag_q[upd_idx]    <= upd_tag;
            target_q[upd_idx] <= upd_target;
            ctr_q[upd_idx]    <= alloc_ctr;
        end else if (wrp && upd_hit) begin
            ctr_q[upd_idx] <= ctr_nxt;
        end
    end

    // Entry seen by the lookup: stored contents, or the entry being written
    // this cycle when forwarding is enabled.
    always_comb begin
        rd_valid  = valid_q[idx];
        rd_tag    = tag_q[idx];
        rd_target = target_q[idx];
        rd_ctr    = ctr_q[idx];
`ifdef BTB_BYPASS_EN
        if (upd_idx == idx) begin
            if (wrt) begin
                rd_valid  = 1'b1;
                rd_tag    = upd_tag;
                rd_target = upd_target;
                rd_ctr    = alloc_ctr;
            end else if (wrp && upd_hit) begin
                rd_ctr = ctr_nxt;
            end
        end
`endif
    end

    assign hit    = rd_valid && (rd_tag == tag);
    assign pred   = hit ? rd_ctr : 2'd0;
    assign target = hit ? rd_target : '0;
    assign hp     = {hit, pred[1]};

    // Decode-stage copy: flush clears even while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpd      <= 2'b00;
            pred_d   <= 2'd0;
            target_d <= '0;
        end else if (flush) begin
            hpd      <= 2'b00;
            pred_d   <= 2'd0;
            target_d <= '0;
        end else if (!stall) begin
            hpd      <= hp;
            pred_d   <= pred;
            target_d <= target;
        end
    end

endmodule
